// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: frame layout, command decode and FSM states.
package spi_target_pkg;

    localparam int CMD_WIDTH    = 8;
    localparam int FRAME_BITS   = 40;
    localparam int CMD_WE_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // True when a 7-bit word address falls inside a bank of 'words' registers.
    function automatic logic addr_in_range(input logic [6:0] addr, input int words);
        return ({25'd0, addr} < $unsigned(words));
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state: shift the pin through the synchronizer and compare against the last level.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    // Synchronizer and pulse registers; reset to the pin's idle level so no false edge appears.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target mapping 8-bit command + 32-bit data frames onto a register bank.
module spi_target #(
    parameter int DATA_WIDTH = 32,
    parameter int TEST_WORDS = 8,
    parameter int CMD_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  spi_ss_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    input  logic [6:0]            loc_addr_i,
    output logic [DATA_WIDTH-1:0] loc_rdata_o,
    output logic                  wr_strobe_o,
    output logic [6:0]            wr_addr_o,
    output logic                  err_o
);
    import spi_target_pkg::*;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic                  mosi_meta_q, mosi_meta_d;
    logic                  mosi_sync_q, mosi_sync_d;
    logic [1:0]            state_q, state_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [CMD_WIDTH-2:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-2:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic [6:0]            addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [6:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] regs_q [TEST_WORDS];
    logic [DATA_WIDTH-1:0] regs_d [TEST_WORDS];

    logic [CMD_WIDTH-1:0]  cmd_next;
    logic [DATA_WIDTH-1:0] rd_word;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (spi_sclk_i),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // Chip select idles high, so its synchronizer resets high.
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (spi_ss_i),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    // mosi synchronizer and combinational local read port (old value until the write registers).
    always_comb begin
        mosi_meta_d = spi_mosi_i;
        mosi_sync_d = mosi_meta_q;
        loc_rdata_o = '0;
        for (int i = 0; i < TEST_WORDS; i++) begin
            if (loc_addr_i == 7'(i)) loc_rdata_o = regs_q[i];
        end
    end

    // Frame FSM: command shift, data shift in/out, commit and abort handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        we_d        = we_q;
        err_d       = err_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        cmd_next = {cmd_q, mosi_sync_q};
        rd_word  = '0;
        for (int i = 0; i < TEST_WORDS; i++) begin
            if (cmd_next[CMD_ADDR_MSB:0] == 7'(i)) rd_word = regs_q[i];
        end

        if (ss_rise) begin
            // Deselect at any point ends the frame without committing anything.
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (ss_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        cmd_d     = '0;
                        rx_d      = '0;
                        tx_d      = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_d     = cmd_next[CMD_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'(CMD_WIDTH - 1)) begin
                            we_d    = cmd_next[CMD_WE_BIT];
                            addr_d  = cmd_next[CMD_ADDR_MSB:0];
                            tx_d    = rd_word;
                            state_d = ST_DATA;
                            if (!addr_in_range(cmd_next[CMD_ADDR_MSB:0], TEST_WORDS)) err_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // Reads present the next bit on each falling edge, MSB first.
                    if (sclk_fall && !we_q) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (we_q) rx_d = {rx_q[DATA_WIDTH-3:0], mosi_sync_q};
                        if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
                            state_d = ST_DONE;
                            miso_d  = 1'b0;
                            if (we_q && addr_in_range(addr_q, TEST_WORDS)) begin
                                for (int i = 0; i < TEST_WORDS; i++) begin
                                    if (addr_q == 7'(i)) regs_d[i] = {rx_q, mosi_sync_q};
                                end
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and register bank; reset clears everything including the bank.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < TEST_WORDS; i++) regs_q[i] <= '0;
        end else begin
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            err_q       <= err_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: an SPI master task drives frames, a reference
// model predicts the bank, and monitors compare write strobes and read data.
module tb_spi_target;

    localparam int NW   = 8;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [6:0]  loc_addr = '0;
    logic [31:0] loc_rdata;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_regs [128];
    logic        ref_err = 1'b0;
    logic [6:0]  exp_wr_q [$];
    logic [31:0] exp_rd_q [$];

    logic        rd_vld = 1'b0;
    logic [31:0] rd_word = '0;

    spi_target #(.DATA_WIDTH(32), .TEST_WORDS(NW), .CMD_WIDTH(8)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .spi_ss_i    (spi_ss),
        .spi_sclk_i  (spi_sclk),
        .spi_mosi_i  (spi_mosi),
        .spi_miso_o  (spi_miso),
        .loc_addr_i  (loc_addr),
        .loc_rdata_o (loc_rdata),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every strobe must match the next predicted commit.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_strobe_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(wr_addr), 32'(exp_wr_q.pop_front()));
            end
        end
    end

    // Read-data monitor: each completed read frame must match the predicted word.
    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_rd_q.size() == 0) check("read_unexpected", rd_word, 32'hDEAD_0000);
            else check("read_data", rd_word, exp_rd_q.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic model_reset();
        for (int k = 0; k < 128; k++) ref_regs[k] = '0;
        ref_err = 1'b0;
    endtask

    task automatic sweep();
        logic [6:0] a;
        for (int k = 0; k <= NW + 2; k++) begin
            a = (k == NW + 2) ? 7'd127 : 7'(k);
            loc_addr = a;
            #1;
            check($sformatf("loc_rdata[%0d]", a), loc_rdata, (a < 7'(NW)) ? ref_regs[a] : 32'h0);
        end
        check("err_o", 32'(err), 32'(ref_err));
    endtask

    // One SPI frame of nrise sclk pulses; rst_at >= 0 pulses reset before that pulse instead.
    task automatic xfer(input logic [7:0] cmd, input logic [31:0] data, input int nrise, input int rst_at);
        logic [39:0] sh;
        logic [31:0] rd;
        logic [6:0]  a;
        logic        we, inr, full;
        int          cmd_miso;
        a    = cmd[6:0];
        we   = cmd[7];
        inr  = (a < 7'(NW));
        full = (nrise >= 40) && (rst_at < 0);
        if (rst_at < 0 && nrise >= 8 && !inr) ref_err = 1'b1;
        if (full && we && inr) begin
            ref_regs[a] = data;
            exp_wr_q.push_back(a);
        end
        if (full && !we) exp_rd_q.push_back(inr ? ref_regs[a] : 32'h0);
        sh = {cmd, data};
        rd = '0;
        cmd_miso = 0;
        @(negedge clk);
        #2;
        spi_ss = 1'b0;
        #HALF;
        for (int i = 0; i < nrise; i++) begin
            spi_mosi = (i < 40) ? sh[39] : 1'b1;
            sh = {sh[38:0], 1'b0};
            #HALF;
            if (i == rst_at) begin
                rstn = 1'b0;
                @(posedge clk);
                #1;
                check("rst_miso", 32'(spi_miso), 32'h0);
                check("rst_err", 32'(err), 32'h0);
                check("rst_strobe", 32'(wr_strobe), 32'h0);
                rstn = 1'b1;
                model_reset();
                break;
            end
            if (i < 8) cmd_miso += int'(spi_miso);
            else if (i < 40) rd = {rd[30:0], spi_miso};
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        #HALF;
        spi_ss = 1'b1;
        spi_mosi = 1'b0;
        #(2 * HALF);
        check("miso_after_ss", 32'(spi_miso), 32'h0);
        if (!we && rst_at < 0 && nrise >= 8) check("miso_cmd_phase", 32'(cmd_miso), 32'h0);
        if (full && !we) begin
            rd_word = rd;
            rd_vld = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            rd_vld = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]  rc;
        logic [31:0] rdat;
        int          nr;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_miso", 32'(spi_miso), 32'h0);
        check("reset_strobe", 32'(wr_strobe), 32'h0);
        check("reset_wr_addr", 32'(wr_addr), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        sweep();

        // Basic write to addr 3.
        xfer(8'h83, 32'hA5A5_0F0F, 40, -1);
        sweep();
        // Write then read back addr 5.
        xfer(8'h85, 32'h1234_5678, 40, -1);
        xfer(8'h05, 32'h0, 40, -1);
        sweep();
        // Out-of-range write and read.
        xfer(8'h8A, 32'hCAFE_F00D, 40, -1);
        sweep();
        xfer(8'h0A, 32'h0, 40, -1);
        sweep();
        // Aborted write after 20 data bits, then a full write to the same register.
        xfer(8'h82, 32'hFFFF_FFFF, 28, -1);
        sweep();
        xfer(8'h82, 32'h0000_00C3, 40, -1);
        sweep();
        // Reset in the middle of a read of an all-ones word, then a normal frame.
        xfer(8'h86, 32'hFFFF_FFFF, 40, -1);
        xfer(8'h06, 32'h0, 40, 18);
        sweep();
        xfer(8'h84, 32'h5A5A_3C3C, 40, -1);
        xfer(8'h04, 32'h0, 40, -1);
        sweep();
        // Overlong frame: extra pulses must be ignored.
        xfer(8'h81, 32'hDEAD_BEEF, 48, -1);
        sweep();

        // Randomized frames.
        for (int t = 0; t < 14; t++) begin
            rc   = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))};
            rdat = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    nr = 40;
                2:       nr = 48;
                default: nr = 8 + $urandom_range(1, 31);
            endcase
            xfer(rc, rdat, nr, -1);
            sweep();
        end

        repeat (10) @(posedge clk);
        #1;
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
